mc_sequencer: RTL and testbench
===============================

MC_SEQUENCER -- requirements
Module: mc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port op_code, input, 7, opcode field of the instruction register; sampled only in DECODE.
REQ-004 SHALL have port if_ready, input, 1, instruction memory response valid.
REQ-005 SHALL have port dm_ready, input, 1, data memory access complete.
REQ-006 SHALL have port if_req, output, 1, instruction fetch request.
REQ-007 SHALL have port ir_we, output, 1, instruction register write strobe.
REQ-008 SHALL have port pc_we, output, 1, program counter update strobe.
REQ-009 SHALL have ports alu_src (1), alu_op (2), mem_r (1), mem_w (1), mem2reg (1) and reg_w (1), all outputs, with the same meaning as the single-cycle decode controls.
REQ-010 SHALL have port illegal, output, 1, sticky flag for an unsupported opcode.
REQ-011 SHALL have port bus_err, output, 1, sticky flag for a memory handshake timeout.
REQ-012 SHALL have port state, output, 3, current FSM state for debug.

Function
REQ-013 SHALL use these state encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to HALT on the next edge.
REQ-014 FETCH SHALL drive if_req=1 and hold the state until if_ready=1; in the if_ready cycle it SHALL pulse ir_we=1 and move to DECODE.
REQ-015 DECODE SHALL register an instruction class from op_code and move to EXEC: 0000011=LOAD, 0100011=STORE, 0010011=IMM, 0110011=REG.
REQ-016 For any other op_code, DECODE SHALL move to HALT and set illegal=1.
REQ-017 alu_src and alu_op SHALL be driven from the registered class in EXEC, MEM and WB, and SHALL be 0 in every other state.
REQ-018 The class mapping SHALL be: LOAD/STORE alu_src=1, alu_op=00; IMM alu_src=1, alu_op=11; REG alu_src=0, alu_op=10.
REQ-019 EXEC SHALL last exactly one cycle and then go to MEM for LOAD/STORE, or to WB for IMM/REG.
REQ-020 MEM SHALL hold mem_r=1 (LOAD) or mem_w=1 (STORE) continuously until dm_ready=1.
REQ-021 On dm_ready in MEM, a LOAD SHALL go to WB; a STORE SHALL pulse pc_we=1 in that cycle and go to FETCH.
REQ-022 WB SHALL last one cycle with reg_w=1, pc_we=1 and mem2reg=1 (LOAD only, else 0), then go to FETCH.
REQ-023 reg_w, mem2reg, mem_r and mem_w SHALL be 0 in all states not listed above; STORE SHALL never assert reg_w.
REQ-024 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle spent waiting for a ready.
REQ-025 If the wait counter reaches 255 without a ready, the FSM SHALL go to HALT and set bus_err=1.
REQ-026 A ready arriving in the same cycle the wait counter hits 255 SHALL take priority over the timeout.
REQ-027 HALT SHALL drive all strobes and controls to 0 and SHALL be left only by reset; illegal and bus_err SHALL hold their values until reset.
REQ-028 Minimum latency with ready asserted immediately SHALL be: IMM/REG 4 cycles, STORE 4 cycles, LOAD 5 cycles, each counted FETCH-entry to FETCH-entry.
REQ-029 The state and the registered class SHALL be flops; all strobes SHALL be Moore/Mealy decodes of state, class and ready only.

Reset
REQ-030 While rst_n=0, state SHALL be FETCH, the class, wait counter, illegal and bus_err SHALL be 0, and every output other than state SHALL be 0.
REQ-031 if_req SHALL rise in the first cycle after rst_n deasserts.
REQ-032 Asserting rst_n=0 in any state, including mid-MEM, SHALL immediately drop mem_r/mem_w to 0 and return to FETCH.

Verification
REQ-033 The bench SHALL check: R-type, if_ready and dm_ready held 1 -> states 0,1,2,4; reg_w=1 and pc_we=1 only in WB; alu_op=10 and alu_src=0 in EXEC/WB.
REQ-034 The bench SHALL check: load, dm_ready delayed 3 cycles -> mem_r high 4 cycles, then WB with mem2reg=1 and reg_w=1; total 8 cycles.
REQ-035 The bench SHALL check: store -> mem_w high until dm_ready, pc_we pulse in that cycle, reg_w never 1, return to FETCH.
REQ-036 The bench SHALL check: op_code=1110011 -> HALT (state=5), illegal=1, all strobes 0 until reset.
REQ-037 The bench SHALL check: dm_ready held 0 in MEM -> HALT with bus_err=1 after 255 wait cycles; a second run with dm_ready at cycle 255 -> no bus_err.
REQ-038 The bench SHALL check: rst_n pulsed low mid-MEM -> mem_r drops in the same cycle, state=0, if_req=1 on the first cycle after release.

Source files
------------

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer (FETCH/DECODE/EXEC/MEM/WB) with handshake
// timeouts and sticky illegal-opcode / bus-error flags.
module mc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_code,
  input  logic       if_ready,
  input  logic       dm_ready,
  output logic       if_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       mem_r,
  output logic       mem_w,
  output logic       mem2reg,
  output logic       reg_w,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] C_LOAD  = 2'd0;
  localparam logic [1:0] C_STORE = 2'd1;
  localparam logic [1:0] C_IMM   = 2'd2;
  localparam logic [1:0] C_REG   = 2'd3;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  localparam logic [7:0] WAIT_MAX = 8'hFF;

  logic [2:0] state_nxt;
  logic [1:0] cls, cls_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       illegal_set, bus_err_set;
  logic       alu_src_c;
  logic [1:0] alu_op_c;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    state_nxt   = state;
    cls_nxt     = cls;
    wait_nxt    = wait_cnt;
    illegal_set = 1'b0;
    bus_err_set = 1'b0;
    case (state)
      S_FETCH: begin
        // A ready in the timeout cycle still wins over the timeout.
        if (if_ready) begin
          state_nxt = S_DECODE;
        end else if (wait_cnt == WAIT_MAX) begin
          state_nxt   = S_HALT;
          bus_err_set = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_DECODE: begin
        state_nxt = S_EXEC;
        case (op_code)
          OP_LOAD:  cls_nxt = C_LOAD;
          OP_STORE: cls_nxt = C_STORE;
          OP_IMM:   cls_nxt = C_IMM;
          OP_REG:   cls_nxt = C_REG;
          default: begin
            state_nxt   = S_HALT;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        if (cls == C_LOAD || cls == C_STORE) begin
          state_nxt = S_MEM;
          wait_nxt  = '0;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (dm_ready) begin
          if (cls == C_LOAD) begin
            state_nxt = S_WB;
          end else begin
            state_nxt = S_FETCH;
            wait_nxt  = '0;
          end
        end else if (wait_cnt == WAIT_MAX) begin
          state_nxt   = S_HALT;
          bus_err_set = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        wait_nxt  = '0;
      end
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      state    <= S_FETCH;
      cls      <= C_LOAD;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cls      <= cls_nxt;
      wait_cnt <= wait_nxt;
      illegal  <= illegal | illegal_set;
      bus_err  <= bus_err | bus_err_set;
    end
  end

  assign alu_src_c = (cls != C_REG);
  assign alu_op_c  = (cls == C_IMM) ? 2'b11 : (cls == C_REG) ? 2'b10 : 2'b00;

  // Strobes are gated by rst_n so they are quiet while reset is held,
  // and if_req appears in the very first cycle after release.
  always_comb begin
    if_req  = 1'b0;
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    alu_src = 1'b0;
    alu_op  = 2'b00;
    mem_r   = 1'b0;
    mem_w   = 1'b0;
    mem2reg = 1'b0;
    reg_w   = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          if_req = 1'b1;
          ir_we  = if_ready;
        end
        S_EXEC: begin
          alu_src = alu_src_c;
          alu_op  = alu_op_c;
        end
        S_MEM: begin
          alu_src = alu_src_c;
          alu_op  = alu_op_c;
          mem_r   = (cls == C_LOAD);
          mem_w   = (cls == C_STORE);
          pc_we   = (cls == C_STORE) && dm_ready;
        end
        S_WB: begin
          alu_src = alu_src_c;
          alu_op  = alu_op_c;
          reg_w   = 1'b1;
          pc_we   = 1'b1;
          mem2reg = (cls == C_LOAD);
        end
        default: begin
          if_req = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: per-instruction traces are generated from
// the phase rules and checked cycle by cycle by an independent monitor.
module tb_mc_sequencer;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_ILL   = 7'b1110011;

  typedef enum int {K_LOAD, K_STORE, K_IMM, K_REG, K_BAD} kind_t;

  typedef struct packed {
    logic [2:0] state;
    logic       if_req;
    logic       ir_we;
    logic       pc_we;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mem_r;
    logic       mem_w;
    logic       mem2reg;
    logic       reg_w;
    logic       illegal;
    logic       bus_err;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op_code;
  logic       if_ready, dm_ready;
  logic       if_req, ir_we, pc_we, alu_src;
  logic [1:0] alu_op;
  logic       mem_r, mem_w, mem2reg, reg_w, illegal, bus_err;
  logic [2:0] state;

  mc_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_code  (op_code),
    .if_ready (if_ready),
    .dm_ready (dm_ready),
    .if_req   (if_req),
    .ir_we    (ir_we),
    .pc_we    (pc_we),
    .alu_src  (alu_src),
    .alu_op   (alu_op),
    .mem_r    (mem_r),
    .mem_w    (mem_w),
    .mem2reg  (mem2reg),
    .reg_w    (reg_w),
    .illegal  (illegal),
    .bus_err  (bus_err),
    .state    (state)
  );

  always #5 clk = ~clk;

  obs_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  logic  m_illegal = 1'b0;
  logic  m_bus_err = 1'b0;

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    obs_t  e;
    obs_t  g;
    string t;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = {state, if_req, ir_we, pc_we, alu_src, alu_op,
           mem_r, mem_w, mem2reg, reg_w, illegal, bus_err};
      n_checks++;
      if (g === e) n_pass++;
      else $display("FAIL %s (cycle %0d): got st=%0d ctl=%b, expected st=%0d ctl=%b",
                    t, cyc, g.state, g[11:0], e.state, e[11:0]);
    end
  end

  function automatic kind_t kind_of(input logic [6:0] op);
    case (op)
      OP_LOAD:  return K_LOAD;
      OP_STORE: return K_STORE;
      OP_IMM:   return K_IMM;
      OP_REG:   return K_REG;
      default:  return K_BAD;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [6:0] rnd7();
    return 7'($urandom);
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t o = '0;
    o.state   = st;
    o.illegal = m_illegal;
    o.bus_err = m_bus_err;
    return o;
  endfunction

  // Class -> ALU control table: LOAD/STORE 1/00, IMM 1/11, REG 0/10.
  function automatic obs_t with_alu(input obs_t o, input kind_t k);
    obs_t r = o;
    r.alu_src = (k != K_REG);
    r.alu_op  = (k == K_IMM) ? 2'b11 : (k == K_REG) ? 2'b10 : 2'b00;
    return r;
  endfunction

  task automatic drive(input logic rv, input logic ifr, input logic dmr,
                       input logic [6:0] op, input obs_t e, input string t);
    @(posedge clk);
    #1;
    rst_n    = rv;
    if_ready = ifr;
    dm_ready = dmr;
    op_code  = op;
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic do_reset(input int n, input string t);
    m_illegal = 1'b0;
    m_bus_err = 1'b0;
    for (int i = 0; i < n; i++) drive(1'b0, rb(), rb(), rnd7(), mk(S_FETCH), t);
  endtask

  task automatic hold_halt(input int n, input string t);
    for (int i = 0; i < n; i++) drive(1'b1, rb(), rb(), rnd7(), mk(S_HALT), t);
  endtask

  // One instruction: if_wait/dm_wait are cycles before the ready arrives,
  // rst_at (>=0) pulls reset during that MEM cycle index instead.
  task automatic run_instr(input logic [6:0] op, input int if_wait, input int dm_wait,
                           input int rst_at, input string t, output bit halted);
    kind_t k = kind_of(op);
    obs_t  e;
    logic  r;
    halted = 1'b0;
    for (int i = 0; i < 256; i++) begin
      r = (i == if_wait);
      e = mk(S_FETCH);
      e.if_req = 1'b1;
      e.ir_we  = r;
      drive(1'b1, r, rb(), rnd7(), e, {t, "/fetch"});
      if (r) break;
      if (i == 255) begin
        m_bus_err = 1'b1;
        halted    = 1'b1;
        return;
      end
    end
    drive(1'b1, rb(), rb(), op, mk(S_DECODE), {t, "/decode"});
    if (k == K_BAD) begin
      m_illegal = 1'b1;
      halted    = 1'b1;
      return;
    end
    drive(1'b1, rb(), rb(), rnd7(), with_alu(mk(S_EXEC), k), {t, "/exec"});
    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; i < 256; i++) begin
        if (i == rst_at) begin
          do_reset(2, {t, "/reset"});
          return;
        end
        r = (i == dm_wait);
        e = with_alu(mk(S_MEM), k);
        e.mem_r = (k == K_LOAD);
        e.mem_w = (k == K_STORE);
        e.pc_we = (k == K_STORE) && r;
        drive(1'b1, rb(), r, rnd7(), e, {t, "/mem"});
        if (r) break;
        if (i == 255) begin
          m_bus_err = 1'b1;
          halted    = 1'b1;
          return;
        end
      end
      if (k == K_STORE) return;
    end
    e = with_alu(mk(S_WB), k);
    e.reg_w   = 1'b1;
    e.pc_we   = 1'b1;
    e.mem2reg = (k == K_LOAD);
    drive(1'b1, rb(), rb(), rnd7(), e, {t, "/wb"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         h;
    logic [6:0] op;
    rst_n    = 1'b0;
    if_ready = 1'b0;
    dm_ready = 1'b0;
    op_code  = '0;

    do_reset(3, "reset");
    run_instr(OP_REG,   0, 0, -1, "rtype", h);
    run_instr(OP_LOAD,  0, 3, -1, "load_dm3", h);
    run_instr(OP_STORE, 1, 2, -1, "store", h);
    run_instr(OP_IMM,   2, 0, -1, "imm", h);

    run_instr(OP_ILL, 0, 0, -1, "illegal", h);
    hold_halt(6, "illegal_halt");
    do_reset(2, "reset");

    run_instr(OP_LOAD, 0, 1000, -1, "dm_timeout", h);
    hold_halt(4, "bus_err_halt");
    do_reset(2, "reset");

    run_instr(OP_STORE, 0, 255, -1, "dm_ready_at_255", h);
    run_instr(OP_REG,   0, 0,   -1, "after_255", h);

    run_instr(OP_IMM, 1000, 0, -1, "if_timeout", h);
    hold_halt(3, "if_timeout_halt");
    do_reset(2, "reset");

    run_instr(OP_LOAD, 0, 1000, 2, "reset_mid_mem", h);
    run_instr(OP_REG,  0, 0,   -1, "after_reset", h);

    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 11))
        0: begin
          op = rnd7();
          while (kind_of(op) != K_BAD) op = rnd7();
        end
        1, 2, 3:  op = OP_LOAD;
        4, 5, 6:  op = OP_STORE;
        7, 8:     op = OP_IMM;
        default:  op = OP_REG;
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 4),
                ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1, "random", h);
      if (h) begin
        hold_halt(2, "random_halt");
        do_reset(2, "random_reset");
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
